// File: rtl/block_scroller.sv
// Playfield owner for the 8x8 falling-blocks game: scrolls rows down, inserts LFSR rows, scores dodged rows.
// Optional macro BLOCK_SCROLLER_SPEEDUP_EN shortens the scroll period as the score grows.
module block_scroller #(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MIN_GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        gameover,
  output logic [63:0] blocks,
  output logic        step,
  output logic [15:0] score,
  output logic        running
);

  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int unsigned GAP_W     = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  state_t            state_q, state_d;
  logic [63:0]       blocks_q, blocks_d;
  logic [15:0]       score_q, score_d;
  logic [31:0]       div_q, div_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              step_q, step_d;
  logic              running_q, running_d;
  logic [31:0]       period_m1;
  logic [7:0]        new_row;
  logic              scroll;

`ifdef BLOCK_SCROLLER_SPEEDUP_EN
  localparam logic [31:0] PERIOD_MAX = 32'(TICK_DIV);
  localparam logic [31:0] PERIOD_DEC = 32'(TICK_DIV / 8);
  localparam logic [31:0] PERIOD_MIN = 32'(TICK_DIV / 4);

  logic [31:0] period_q, period_d;

  assign period_m1 = period_q - 32'd1;

  function automatic logic [31:0] shorten(input logic [31:0] p);
    if (p >= PERIOD_MIN + PERIOD_DEC) shorten = p - PERIOD_DEC;
    else                              shorten = PERIOD_MIN;
  endfunction
`else
  assign period_m1 = 32'(TICK_DIV - 1);
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] gen_row(input logic [15:0] l);
    gen_row = (8'd1 << l[2:0]) | (l[3] ? (8'd1 << l[6:4]) : 8'd0);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      blocks_q  <= 64'd0;
      score_q   <= 16'd0;
      div_q     <= 32'd0;
      gap_q     <= '0;
      lfsr_q    <= SEED_EFF;
      step_q    <= 1'b0;
      running_q <= 1'b0;
`ifdef BLOCK_SCROLLER_SPEEDUP_EN
      period_q  <= PERIOD_MAX;
`endif
    end else begin
      state_q   <= state_d;
      blocks_q  <= blocks_d;
      score_q   <= score_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_d;
      step_q    <= step_d;
      running_q <= running_d;
`ifdef BLOCK_SCROLLER_SPEEDUP_EN
      period_q  <= period_d;
`endif
    end
  end

  // Next-state logic; gameover takes priority over a coincident scroll
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)    state_d = S_RUN;
      S_RUN:   if (gameover) state_d = S_OVER;
      S_OVER:  if (start)    state_d = S_RUN;
      default:               state_d = S_IDLE;
    endcase
  end

  assign scroll  = (state_q == S_RUN) && !gameover && (div_q == period_m1);
  assign new_row = (gap_q != '0) ? 8'h00 : gen_row(lfsr_q);

  // Datapath and registered outputs
  always_comb begin
    blocks_d  = blocks_q;
    score_d   = score_q;
    div_d     = div_q;
    gap_d     = gap_q;
    step_d    = 1'b0;
    running_d = (state_d == S_RUN);
    lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
`ifdef BLOCK_SCROLLER_SPEEDUP_EN
    period_d  = period_q;
`endif
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          blocks_d = 64'd0;
          score_d  = 16'd0;
          div_d    = 32'd0;
          gap_d    = '0;
`ifdef BLOCK_SCROLLER_SPEEDUP_EN
          period_d = PERIOD_MAX;
`endif
        end
      end
      S_RUN: begin
        if (!gameover) div_d = div_q + 32'd1;
        if (scroll) begin
          div_d    = 32'd0;
          blocks_d = {new_row, blocks_q[63:8]};
          gap_d    = (gap_q != '0) ? gap_q - GAP_W'(1) : GAP_LOAD;
          step_d   = 1'b1;
          if (blocks_q[7:0] != 8'h00) begin
            score_d = sat_inc(score_q);
`ifdef BLOCK_SCROLLER_SPEEDUP_EN
            if (score_q != 16'hFFFF && score_d[3:0] == 4'h0) period_d = shorten(period_q);
`endif
          end
        end
      end
      default: ;
    endcase
  end

  assign blocks  = blocks_q;
  assign score   = score_q;
  assign step    = step_q;
  assign running = running_q;

endmodule
